// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory_manager port among requesters
module mem_port_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int READ_LAT = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [24*NUM_REQ-1:0] req_addr,
    input  logic [16*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [15:0]           rdata,
    output logic [23:0]           mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  mem_we,
    output logic                  mem_req,
    input  logic [15:0]           mem_rdata
);

    localparam int IDW   = (NUM_REQ > 2) ? 2 : 1;
    // Entries in flight before the stage that captures mem_rdata
    localparam int DEPTH = READ_LAT - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_last;
    logic [IDW-1:0]   w_winner;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic [DEPTH-1:0] r_pipe_vld;
    logic [DEPTH-1:0] w_pipe_vld_nxt;
    logic [IDW-1:0]   r_pipe_id [DEPTH];
    logic             w_head_vld;
    logic [IDW-1:0]   w_head_id;

    // Round-robin pick: scan upward from the requester after the last winner
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        gnt      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDW'((int'(r_last) + k) % NUM_REQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
        if (w_any) begin
            gnt[w_winner] = 1'b1;
        end
    end

    // Next contents of the read-tracking shift register and the port state
    always_comb begin
        w_pipe_vld_nxt    = '0;
        w_pipe_vld_nxt[0] = w_any && !req_we[w_winner];
        for (int i = 1; i < DEPTH; i++) begin
            w_pipe_vld_nxt[i] = r_pipe_vld[i-1];
        end
        w_head_vld = r_pipe_vld[DEPTH-1];
        w_head_id  = r_pipe_id[DEPTH-1];
        case (r_state)
            S_IDLE:  w_state_nxt = w_any ? S_BUSY : S_IDLE;
            S_BUSY,
            S_DRAIN: w_state_nxt = w_any ? S_BUSY :
                                   (|w_pipe_vld_nxt) ? S_DRAIN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Issue the winner, advance the read pipeline, return read data, track port state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_last     <= IDW'(NUM_REQ - 1);
            r_pipe_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe_id[i] <= '0;
            end
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_req    <= 1'b0;
            rvalid     <= '0;
            rdata      <= '0;
        end else begin
            if (w_any) begin
                mem_addr  <= req_addr[int'(w_winner)*24 +: 24];
                mem_wdata <= req_wdata[int'(w_winner)*16 +: 16];
                mem_we    <= req_we[w_winner];
                r_last    <= w_winner;
            end else begin
                mem_we    <= 1'b0;
                mem_wdata <= '0;
            end

            r_pipe_vld   <= w_pipe_vld_nxt;
            r_pipe_id[0] <= w_winner;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe_id[i] <= r_pipe_id[i-1];
            end

            rvalid <= '0;
            rdata  <= '0;
            if (w_head_vld) begin
                rvalid[w_head_id] <= 1'b1;
                rdata             <= mem_rdata;
            end

            // The port must stay requested until the last in-flight read has been captured
            r_state <= w_state_nxt;
            mem_req <= (w_state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_we;
    logic [71:0] req_addr;
    logic [47:0] req_wdata;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [15:0] rdata;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic [15:0] mem_rdata;

    int checks;
    int failures;

    mem_port_arbiter #(.NUM_REQ(3), .READ_LAT(3)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_req   (mem_req),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Block RAM model: untouched locations return a fixed pattern
    logic [15:0]  mem_arr [256];
    logic [255:0] mem_wr;
    logic [15:0]  mem_q;

    function automatic logic [15:0] dflt(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a ^ 8'h5A, a};
    endfunction

    always @(posedge clock) begin
        if (!reset_n) begin
            mem_wr <= '0;
        end else if (mem_req && mem_we) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
            mem_wr[mem_addr[7:0]]  <= 1'b1;
        end
        mem_q <= !mem_req ? 16'h0 :
                 mem_wr[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]] : dflt(mem_addr[7:0]);
    end
    assign mem_rdata = mem_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [23:0] a, input logic [15:0] d);
        req_valid[i]         = 1'b1;
        req_we[i]            = we;
        req_addr[24*i +: 24] = a;
        req_wdata[16*i +: 16] = d;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        do_reset();

        // Reset state
        #1;
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_gnt", gnt, 0);

        // Single read by r1
        set_req(1, 1'b0, 24'h000010, 16'h0);
        #1;
        check("rd1_gnt", gnt, 3'b010);
        tick();
        req_valid = '0;
        #1;
        check("rd1_gnt_off", gnt, 0);
        check("rd1_mem_addr", mem_addr, 24'h000010);
        check("rd1_mem_req", mem_req, 1);
        check("rd1_mem_we", mem_we, 0);
        check("rd1_rvalid_t1", rvalid, 0);
        tick();
        check("rd1_rvalid_t2", rvalid, 0);
        check("rd1_mem_req_t2", mem_req, 1);
        tick();
        check("rd1_rvalid_t3", rvalid, 3'b010);
        check("rd1_rdata_t3", rdata, 16'hBEEF);
        check("rd1_mem_req_t3", mem_req, 0);
        tick();
        check("rd1_rvalid_t4", rvalid, 0);
        check("rd1_rdata_t4", rdata, 0);

        // Write then read by r0
        set_req(0, 1'b1, 24'h000020, 16'h1234);
        #1;
        check("wr_gnt", gnt, 3'b001);
        tick();
        set_req(0, 1'b0, 24'h000020, 16'h0);
        #1;
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 24'h000020);
        check("wr_mem_wdata", mem_wdata, 16'h1234);
        check("wrrd_gnt", gnt, 3'b001);
        tick();
        req_valid = '0;
        #1;
        check("wrrd_mem_we_low", mem_we, 0);
        check("wrrd_rvalid_g1", rvalid, 0);
        tick();
        check("wrrd_rvalid_g2", rvalid, 0);
        tick();
        check("wrrd_rvalid_g3", rvalid, 3'b001);
        check("wrrd_rdata_g3", rdata, 16'h1234);
        tick();
        check("wrrd_rvalid_g4", rvalid, 0);

        // Contention: all three reading from the first cycle after reset
        do_reset();
        set_req(0, 1'b0, 24'h000030, 16'h0);
        set_req(1, 1'b0, 24'h000040, 16'h0);
        set_req(2, 1'b0, 24'h000050, 16'h0);
        for (int c = 0; c < 9; c++) begin
            if (c == 6) req_valid = '0;
            #1;
            check($sformatf("cont_gnt_c%0d", c), gnt, (c < 6) ? (3'b001 << (c % 3)) : 3'b000);
            check($sformatf("cont_rvalid_c%0d", c), rvalid, (c >= 3) ? (3'b001 << ((c - 3) % 3)) : 3'b000);
            if (c >= 3)
                check($sformatf("cont_rdata_c%0d", c), rdata, dflt(8'h30 + 8'h10 * 8'((c - 3) % 3)));
            check($sformatf("cont_mem_req_c%0d", c), mem_req, (c >= 1 && c <= 7) ? 1 : 0);
            tick();
        end

        // Mixed stream from r2: read, write, read
        set_req(2, 1'b0, 24'h000060, 16'h0);
        #1;
        check("mix_gnt0", gnt, 3'b100);
        tick();
        set_req(2, 1'b1, 24'h000070, 16'h5555);
        #1;
        check("mix_gnt1", gnt, 3'b100);
        check("mix_we_g1", mem_we, 0);
        tick();
        set_req(2, 1'b0, 24'h000070, 16'h0);
        #1;
        check("mix_gnt2", gnt, 3'b100);
        check("mix_we_g2", mem_we, 1);
        check("mix_rvalid_g2", rvalid, 0);
        tick();
        req_valid = '0;
        #1;
        check("mix_we_g3", mem_we, 0);
        check("mix_rvalid_g3", rvalid, 3'b100);
        check("mix_rdata_g3", rdata, dflt(8'h60));
        check("mix_req_g3", mem_req, 1);
        tick();
        check("mix_rvalid_g4", rvalid, 0);
        check("mix_req_g4", mem_req, 1);
        tick();
        check("mix_rvalid_g5", rvalid, 3'b100);
        check("mix_rdata_g5", rdata, 16'h5555);
        check("mix_req_g5", mem_req, 0);
        tick();
        check("mix_rvalid_g6", rvalid, 0);

        // Reset one cycle after a read grant
        set_req(0, 1'b0, 24'h000010, 16'h0);
        #1;
        check("rstf_gnt", gnt, 3'b001);
        tick();
        req_valid = '0;
        check("rstf_mem_req_pre", mem_req, 1);
        reset_n = 1'b0;
        #1;
        check("rstf_mem_req", mem_req, 0);
        check("rstf_mem_addr", mem_addr, 0);
        check("rstf_rvalid", rvalid, 0);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("rstf_quiet_c%0d", c), rvalid, 0);
            tick();
        end
        set_req(0, 1'b0, 24'h000031, 16'h0);
        set_req(2, 1'b0, 24'h000032, 16'h0);
        #1;
        check("rstf_first_gnt", gnt, 3'b001);
        tick();
        req_valid[0] = 1'b0;
        #1;
        check("rstf_second_gnt", gnt, 3'b100);
        tick();
        req_valid = '0;

        // Held request: r1 waits while r2 and r0 take their turns
        set_req(1, 1'b0, 24'h000041, 16'h0);
        #1;
        check("held_lone0", gnt, 3'b010);
        tick();
        #1;
        check("held_lone1", gnt, 3'b010);
        tick();
        set_req(0, 1'b0, 24'h000042, 16'h0);
        set_req(1, 1'b0, 24'h000043, 16'h0);
        set_req(2, 1'b0, 24'h000044, 16'h0);
        #1;
        check("held_gnt0", gnt, 3'b100);
        tick();
        req_valid[2] = 1'b0;
        #1;
        check("held_addr0", mem_addr, 24'h000044);
        check("held_gnt1", gnt, 3'b001);
        tick();
        req_valid[0] = 1'b0;
        #1;
        check("held_addr1", mem_addr, 24'h000042);
        check("held_gnt2", gnt, 3'b010);
        tick();
        req_valid = '0;
        #1;
        check("held_addr2", mem_addr, 24'h000043);
        check("held_gnt_idle", gnt, 0);
        for (int c = 0; c < 4; c++) tick();
        check("held_final_req", mem_req, 0);
        check("held_final_rvalid", rvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
